// File: rtl/kernel_bc_fifo_param.sv
// kernel_bc_fifo_param
//   Parametrised stream FIFO for kernel_bc dataflow channels with an
//   HLS-style handshake and first-word-fall-through head.
//
//   Storage is chosen by MEM_STYLE:
//     "shiftreg" : DEPTH-entry shift register, head read at count-1.
//     "ram"      : circular buffer (wp/rp wrap at DEPTH-1) with a
//                  synchronous-read memory feeding an output register.
//
//   Handshake (valid/ready):
//     push = if_write & if_write_ce & if_full_n   (producer side)
//     pop  = if_read  & if_read_ce  & if_empty_n  (consumer side)
//     A request while the matching ready is low is dropped and sets the
//     sticky if_overflow / if_underflow flag.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     if_empty_n/if_dout  head valid / head word
//     if_read, if_read_ce read request and qualifier
//     if_full_n           space available
//     if_write, if_write_ce, if_din  write request, qualifier, data
//     if_count            words stored (0..DEPTH)
//     if_almost_full_n    0 when count >= DEPTH-AF_MARGIN
//     if_almost_empty_n   0 when count <= AE_MARGIN
//     if_overflow, if_underflow      sticky error flags
module kernel_bc_fifo_param #(
   parameter     MEM_STYLE  = "shiftreg",
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2,
   parameter int DEPTH      = 4,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic [ADDR_WIDTH:0]   if_count,
   output logic                  if_almost_full_n,
   output logic                  if_almost_empty_n,
   output logic                  if_overflow,
   output logic                  if_underflow
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

   logic          push;
   logic          pop;
   logic          empty_n_q;
   logic          full_n_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_next;
   logic          afull_n_q;
   logic          aempty_n_q;
   logic          overflow_q;
   logic          underflow_q;

   assign push = if_write & if_write_ce & full_n_q;
   assign pop  = if_read & if_read_ce & empty_n_q;

   always_comb begin
      count_next = count_q + CW'(push) - CW'(pop);
   end

   // Status registers: all derived from count_next, never from raw inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         full_n_q    <= 1'b1;
         afull_n_q   <= 1'b1;
         aempty_n_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q    <= count_next;
         full_n_q   <= (count_next != FULL_LVL);
         afull_n_q  <= !(count_next >= AF_LVL);
         aempty_n_q <= !(count_next <= AE_LVL);
         if (if_write & if_write_ce & !full_n_q)
            overflow_q <= 1'b1;
         if (if_read & if_read_ce & !empty_n_q)
            underflow_q <= 1'b1;
      end
   end

   generate
      if (MEM_STYLE == "ram") begin : g_ram
         localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

         logic [DATA_WIDTH-1:0] ram_mem [DEPTH];
         logic [ADDR_WIDTH-1:0] wp_q;
         logic [ADDR_WIDTH-1:0] rp_q;
         logic [CW-1:0]         mem_cnt_q;   // words in memory, excluding output register
         logic                  out_valid_q;
         logic [DATA_WIDTH-1:0] out_data_q;
         logic                  rd_issue;

         // Prefetch whenever the output register is free (or being freed
         // by this cycle's pop) and memory has something to give.
         assign rd_issue = (!out_valid_q | pop) & (mem_cnt_q != '0);

         always_ff @(posedge clk) begin
            if (push)
               ram_mem[wp_q] <= if_din;
         end

         // Synchronous memory read lands directly in the output register.
         always_ff @(posedge clk) begin
            if (rd_issue)
               out_data_q <= ram_mem[rp_q];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               wp_q        <= '0;
               rp_q        <= '0;
               mem_cnt_q   <= '0;
               out_valid_q <= 1'b0;
            end else begin
               if (push)
                  wp_q <= (wp_q == LAST_ADDR) ? '0 : wp_q + 1'b1;
               if (rd_issue)
                  rp_q <= (rp_q == LAST_ADDR) ? '0 : rp_q + 1'b1;
               mem_cnt_q <= mem_cnt_q + CW'(push) - CW'(rd_issue);
               if (rd_issue)
                  out_valid_q <= 1'b1;
               else if (pop)
                  out_valid_q <= 1'b0;
            end
         end

         assign empty_n_q = out_valid_q;
         assign if_dout   = out_data_q;
      end else begin : g_shiftreg
         logic [DATA_WIDTH-1:0] sr_mem [DEPTH];
         logic [ADDR_WIDTH-1:0] rd_idx;
         logic                  sr_empty_n_q;

         always_ff @(posedge clk) begin
            if (push) begin
               sr_mem[0] <= if_din;
               for (int i = 1; i < DEPTH; i++)
                  sr_mem[i] <= sr_mem[i-1];
            end
         end

         // Oldest word sits at count-1; clamp to 0 when empty.
         always_comb begin
            rd_idx = '0;
            if (count_q != '0)
               rd_idx = ADDR_WIDTH'(count_q - CW'(1));
         end

         always_ff @(posedge clk) begin
            if (reset)
               sr_empty_n_q <= 1'b0;
            else
               sr_empty_n_q <= (count_next != '0);
         end

         assign empty_n_q = sr_empty_n_q;
         assign if_dout   = sr_mem[rd_idx];
      end
   endgenerate

   assign if_empty_n        = empty_n_q;
   assign if_full_n         = full_n_q;
   assign if_count          = count_q;
   assign if_almost_full_n  = afull_n_q;
   assign if_almost_empty_n = aempty_n_q;
   assign if_overflow       = overflow_q;
   assign if_underflow      = underflow_q;

endmodule

// File: tb/tb_kernel_bc_fifo_param.sv
module tb_kernel_bc_fifo_param;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // u_sr: shiftreg, DEPTH=4
   logic        sr_empty_n, sr_read, sr_full_n, sr_write, sr_afn, sr_aen, sr_ovf, sr_unf;
   logic [31:0] sr_dout, sr_din;
   logic [2:0]  sr_count;
   // u_ram: ram, DEPTH=5
   logic        ram_empty_n, ram_read, ram_full_n, ram_write, ram_afn, ram_aen, ram_ovf, ram_unf;
   logic [31:0] ram_dout, ram_din;
   logic [3:0]  ram_count;
   // u_th: shiftreg, DEPTH=16, AF=3, AE=2
   logic        th_empty_n, th_read, th_full_n, th_write, th_afn, th_aen, th_ovf, th_unf;
   logic [31:0] th_dout, th_din;
   logic [4:0]  th_count;

   kernel_bc_fifo_param #(.MEM_STYLE("shiftreg"), .DATA_WIDTH(32), .ADDR_WIDTH(2),
                          .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1)) u_sr (
      .clk(clk), .reset(reset), .if_empty_n(sr_empty_n), .if_read_ce(1'b1),
      .if_read(sr_read), .if_dout(sr_dout), .if_full_n(sr_full_n), .if_write_ce(1'b1),
      .if_write(sr_write), .if_din(sr_din), .if_count(sr_count),
      .if_almost_full_n(sr_afn), .if_almost_empty_n(sr_aen),
      .if_overflow(sr_ovf), .if_underflow(sr_unf));

   kernel_bc_fifo_param #(.MEM_STYLE("ram"), .DATA_WIDTH(32), .ADDR_WIDTH(3),
                          .DEPTH(5), .AF_MARGIN(1), .AE_MARGIN(1)) u_ram (
      .clk(clk), .reset(reset), .if_empty_n(ram_empty_n), .if_read_ce(1'b1),
      .if_read(ram_read), .if_dout(ram_dout), .if_full_n(ram_full_n), .if_write_ce(1'b1),
      .if_write(ram_write), .if_din(ram_din), .if_count(ram_count),
      .if_almost_full_n(ram_afn), .if_almost_empty_n(ram_aen),
      .if_overflow(ram_ovf), .if_underflow(ram_unf));

   kernel_bc_fifo_param #(.MEM_STYLE("shiftreg"), .DATA_WIDTH(32), .ADDR_WIDTH(4),
                          .DEPTH(16), .AF_MARGIN(3), .AE_MARGIN(2)) u_th (
      .clk(clk), .reset(reset), .if_empty_n(th_empty_n), .if_read_ce(1'b1),
      .if_read(th_read), .if_dout(th_dout), .if_full_n(th_full_n), .if_write_ce(1'b1),
      .if_write(th_write), .if_din(th_din), .if_count(th_count),
      .if_almost_full_n(th_afn), .if_almost_empty_n(th_aen),
      .if_overflow(th_ovf), .if_underflow(th_unf));

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int rd_next;
   int wr_next;
   int occ;
   int cyc;
   int c;
   logic want_w;

   initial begin
      reset = 1'b1;
      sr_read = 0;  sr_write = 0;  sr_din = '0;
      ram_read = 0; ram_write = 0; ram_din = '0;
      th_read = 0;  th_write = 0;  th_din = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_count",    32'(sr_count), 0);
      chk("rst_empty_n",  32'(sr_empty_n), 0);
      chk("rst_full_n",   32'(sr_full_n), 1);
      chk("rst_afn",      32'(sr_afn), 1);
      chk("rst_aen",      32'(sr_aen), 0);
      chk("rst_ovf",      32'(sr_ovf), 0);
      chk("rst_unf",      32'(sr_unf), 0);
      chk("rst_ram_empty_n", 32'(ram_empty_n), 0);

      // Shiftreg fill A0..A3
      for (int i = 0; i < 4; i++) begin
         sr_write = 1; sr_din = 32'hA0 + 32'(i);
         tick();
         chk("fill_count", 32'(sr_count), 32'(i + 1));
         chk("fill_empty_n", 32'(sr_empty_n), 1);
         chk("fill_head", sr_dout, 32'hA0);
         chk("fill_afn", 32'(sr_afn), (i + 1 >= 3) ? 0 : 1);
         chk("fill_aen", 32'(sr_aen), (i + 1 <= 1) ? 0 : 1);
         chk("fill_full_n", 32'(sr_full_n), (i == 3) ? 0 : 1);
      end
      sr_write = 0;

      // Drain in order
      for (int i = 0; i < 4; i++) begin
         chk("drain_head", sr_dout, 32'hA0 + 32'(i));
         sr_read = 1;
         tick();
      end
      sr_read = 0;
      chk("drain_empty_n", 32'(sr_empty_n), 0);
      chk("drain_count", 32'(sr_count), 0);
      chk("drain_full_n", 32'(sr_full_n), 1);

      // Full with simultaneous read+write
      for (int i = 0; i < 4; i++) begin
         sr_write = 1; sr_din = 32'hB0 + 32'(i);
         tick();
      end
      chk("full_full_n", 32'(sr_full_n), 0);
      sr_write = 1; sr_din = 32'hB4; sr_read = 1;
      tick();
      sr_write = 0;
      chk("ovf_flag", 32'(sr_ovf), 1);
      chk("ovf_count", 32'(sr_count), 3);
      chk("ovf_full_n", 32'(sr_full_n), 1);
      for (int i = 1; i < 4; i++) begin
         chk("ovf_head", sr_dout, 32'hB0 + 32'(i));
         sr_read = 1;
         tick();
      end
      sr_read = 0;
      chk("ovf_drained", 32'(sr_count), 0);

      // Empty read with concurrent write
      sr_read = 1; sr_write = 1; sr_din = 32'h55;
      tick();
      sr_read = 0; sr_write = 0;
      chk("unf_flag", 32'(sr_unf), 1);
      chk("unf_count", 32'(sr_count), 1);
      chk("unf_empty_n", 32'(sr_empty_n), 1);
      chk("unf_head", sr_dout, 32'h55);
      chk("ovf_sticky", 32'(sr_ovf), 1);
      sr_read = 1;
      tick();
      sr_read = 0;
      chk("unf_drained", 32'(sr_count), 0);

      // Ram mode: first-push latency
      ram_write = 1; ram_din = 32'h1;
      tick();
      ram_write = 0;
      chk("ram_lat_empty_n1", 32'(ram_empty_n), 0);
      chk("ram_lat_count", 32'(ram_count), 1);
      tick();
      chk("ram_lat_empty_n2", 32'(ram_empty_n), 1);
      chk("ram_lat_head", ram_dout, 32'h1);

      // Ram mode: stream 0x1..0x20 with random stalls
      rd_next = 1; wr_next = 2; occ = 1; cyc = 0;
      while (rd_next <= 32 && cyc < 2000) begin
         want_w    = (wr_next <= 32) && ($urandom_range(0, 3) != 0);
         ram_write = want_w & ram_full_n;
         ram_din   = 32'(wr_next);
         ram_read  = ($urandom_range(0, 2) != 0) & ram_empty_n;
         if (ram_read) begin
            chk("ram_stream_data", ram_dout, 32'(rd_next));
            rd_next++;
            occ--;
         end
         if (ram_write) begin
            wr_next++;
            occ++;
         end
         tick();
         chk("ram_stream_count", 32'(ram_count), 32'(occ));
         cyc++;
      end
      ram_read = 0; ram_write = 0;
      chk("ram_stream_done", 32'(rd_next), 33);
      chk("ram_stream_empty_n", 32'(ram_empty_n), 0);

      // Ram mode: fill to DEPTH then back-to-back pops
      for (int i = 0; i < 5; i++) begin
         ram_write = 1; ram_din = 32'h40 + 32'(i);
         tick();
      end
      ram_write = 0;
      tick();
      chk("ram_full_count", 32'(ram_count), 5);
      chk("ram_full_n", 32'(ram_full_n), 0);
      for (int i = 0; i < 5; i++) begin
         chk("ram_b2b_empty_n", 32'(ram_empty_n), 1);
         chk("ram_b2b_data", ram_dout, 32'h40 + 32'(i));
         ram_read = 1;
         tick();
      end
      ram_read = 0;
      chk("ram_b2b_count", 32'(ram_count), 0);
      chk("ram_b2b_empty_n_end", 32'(ram_empty_n), 0);
      chk("ram_ovf", 32'(ram_ovf), 0);
      chk("ram_unf", 32'(ram_unf), 0);

      // Thresholds DEPTH=16, AF=3 (low at >=13), AE=2 (low at <=2)
      for (int i = 0; i < 13; i++) begin
         th_write = 1; th_din = 32'h100 + 32'(i);
         tick();
         c = i + 1;
         chk("th_fill_afn", 32'(th_afn), (c >= 13) ? 0 : 1);
         chk("th_fill_aen", 32'(th_aen), (c <= 2) ? 0 : 1);
      end
      th_write = 0;
      chk("th_count13", 32'(th_count), 13);
      for (int i = 0; i < 11; i++) begin
         th_read = 1;
         tick();
         c = 12 - i;
         chk("th_drain_afn", 32'(th_afn), (c >= 13) ? 0 : 1);
         chk("th_drain_aen", 32'(th_aen), (c <= 2) ? 0 : 1);
      end
      th_read = 0;
      chk("th_count2", 32'(th_count), 2);
      chk("th_head", th_dout, 32'h10B);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) begin
         sr_write = 1; sr_din = 32'hC0 + 32'(i);
         tick();
      end
      sr_write = 0;
      chk("mid_count3", 32'(sr_count), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_count", 32'(sr_count), 0);
      chk("mid_rst_empty_n", 32'(sr_empty_n), 0);
      chk("mid_rst_full_n", 32'(sr_full_n), 1);
      chk("mid_rst_ovf", 32'(sr_ovf), 0);
      chk("mid_rst_unf", 32'(sr_unf), 0);
      chk("mid_rst_aen", 32'(sr_aen), 0);
      sr_write = 1; sr_din = 32'h77;
      tick();
      sr_write = 0;
      chk("mid_post_head", sr_dout, 32'h77);
      chk("mid_post_count", 32'(sr_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/kernel_bc_fifo_param.md
Name: kernel_bc_fifo_param

Overview:
- Parametrised, general-purpose stream FIFO for kernel_bc dataflow channels.
- Keeps the HLS-style handshake: if_empty_n, if_read/_ce, if_full_n, if_write/_ce.
- Generalised in DATA_WIDTH and DEPTH, including non-power-of-two depths.
- Adds a selectable storage mode (shift register or circular RAM), an occupancy count, almost-full/almost-empty flags and sticky overflow/underflow error flags, so deep channels can use BRAM and producers can throttle early.

Parameters:
MEM_STYLE, "shiftreg", "shiftreg" = SRL shift-register storage; "ram" = circular buffer with synchronous-read memory plus output register
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 2, address width; DEPTH <= 2^ADDR_WIDTH required
DEPTH, 4, capacity in words, 2 <= DEPTH <= 2^ADDR_WIDTH
AF_MARGIN, 1, almost-full asserts when count >= DEPTH-AF_MARGIN, range 0..DEPTH-1
AE_MARGIN, 1, almost-empty asserts when count <= AE_MARGIN, range 0..DEPTH-1

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
if_empty_n  output  1  1 = if_dout holds a valid head word (first-word-fall-through)
if_read_ce  input  1  read enable qualifier
if_read  input  1  read request; a pop occurs when if_read & if_read_ce & if_empty_n
if_dout  output  DATA_WIDTH  head word; value undefined while if_empty_n=0
if_full_n  output  1  1 = can accept a write
if_write_ce  input  1  write enable qualifier
if_write  input  1  write request; a push occurs when if_write & if_write_ce & if_full_n
if_din  input  DATA_WIDTH  write data
if_count  output  ADDR_WIDTH+1  words stored, 0..DEPTH
if_almost_full_n  output  1  0 when count >= DEPTH-AF_MARGIN
if_almost_empty_n  output  1  0 when count <= AE_MARGIN
if_overflow  output  1  sticky; set by a write attempt while if_full_n=0
if_underflow  output  1  sticky; set by a read attempt while if_empty_n=0

Behaviour:
- Reset (synchronous, active-high, on clk): count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1, if_almost_empty_n=0, both error flags 0, pointers 0. Memory contents are not cleared.
- Reset mid-operation discards all stored words; the first post-reset push is the next head.
- All status outputs are registered. Flags use the current count and accepted push/pop to compute next-cycle values; none are combinational from the inputs.
- Count update: count_next = count + push - pop. Push and pop in the same cycle leave count unchanged. Count never exceeds DEPTH and never goes below 0.
- if_full_n = (count_next != DEPTH), registered.
- Full boundary: a write while full is rejected and sets if_overflow, even if a pop occurs in the same cycle. if_full_n rises one cycle after the pop.
- Empty boundary: a read while if_empty_n=0 is ignored and sets if_underflow. A write in that cycle is still accepted.
- "shiftreg" mode:
  - Storage is a DEPTH-entry shift register; data shifts in on push.
  - Head is read at address count-1.
  - Write-to-if_empty_n latency is 1 cycle.
  - if_empty_n = (count_next != 0).
- "ram" mode:
  - Storage is DEPTH-entry memory with write pointer wp and read pointer rp.
  - Pointers wrap from DEPTH-1 to 0, so any DEPTH is supported.
  - An output register holds the head; count includes the output-register word.
  - Prefetch: when the output register is empty or being popped, and memory holds words, issue a memory read that cycle. The data loads into the output register the next cycle.
  - Write-to-if_empty_n latency on an empty FIFO is 2 cycles.
  - Back-to-back pops sustain 1 word/cycle once the FIFO is primed.
  - if_empty_n reflects output-register validity, so it may lag count by 1 cycle.
- Ordering is strict FIFO in both modes; no word is lost or duplicated across wrap-around.
- Almost flags are registered from count_next. With AF_MARGIN=0, if_almost_full_n equals if_full_n.
- Error flags clear only on reset.

Test Plan:
- Shiftreg mode, DEPTH=4: push 0xA0..0xA3 on consecutive cycles -> if_full_n=0 the cycle after the 4th push, if_count=4; pop 4 -> dout 0xA0,0xA1,0xA2,0xA3, if_empty_n=0 the cycle after the last pop.
- Full with simultaneous read+write, DEPTH=4: 5th write with a pop -> write rejected, if_overflow=1, if_count=3; next cycle if_full_n=1.
- Ram mode, DEPTH=5 (non-power-of-two): stream 0x1..0x20 with random read/write stalls -> output order exactly 0x1..0x20 across pointer wrap; first if_empty_n rises 2 cycles after the first push.
- Thresholds, DEPTH=16, AF_MARGIN=3, AE_MARGIN=2: fill to 13 -> if_almost_full_n=0; drain to 2 -> if_almost_empty_n=0; at 3 -> if_almost_empty_n=1.
- Empty read: pop with if_empty_n=0 plus a concurrent write of 0x55 -> if_underflow=1, if_count=1, head=0x55.
- Reset mid-stream with count=3 -> next cycle if_count=0, if_empty_n=0, if_full_n=1, errors 0; a subsequent push of 0x77 is the next dout.
